// File: rtl/ysyx_22040632_icache_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_icache_ctrl
//
// Sequencing controller for the instruction cache data array (2 ways,
// 32 sets, 64-byte lines). A fetch is accepted in IDLE while the data array
// read is launched the same cycle, and it resolves in LOOKUP from the
// external tag-compare results. A miss issues a 4-beat 128-bit AXI read
// burst. Each beat is written into the victim way. The requested word is
// returned once the burst ends, and the tag is written only if the refill
// was error free. One replacement bit per set names the next victim way.
// ---------------------------------------------------------------------------
module ysyx_22040632_icache_ctrl #(
    parameter int TAG_W = 21,
    parameter int SETS  = 32
) (
    input  logic         clk,
    input  logic         rrst_n,

    // IFU fetch interface
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    output logic         rsp_valid,
    output logic [31:0]  rsp_data,
    output logic         rsp_err,

    // tag array
    input  logic         hit_way0,
    input  logic         hit_way1,
    output logic         tag_wen,
    output logic         tag_way,
    output logic [4:0]   tag_index,

    // data array (synchronous SRAM, active-low enables)
    output logic         da_wen,
    output logic         da_w_way,
    output logic [4:0]   da_index,
    output logic [1:0]   da_inside,
    output logic [127:0] da_mask,
    output logic [127:0] da_wdata,
    input  logic [127:0] da_q0,
    input  logic [127:0] da_q1,

    // AXI read channels
    output logic         arvalid,
    input  logic         arready,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    input  logic         rvalid,
    output logic         rready,
    input  logic [127:0] rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast
);

    // Index width follows from the tag width and the 64-byte line offset.
    localparam int IDX_W = 32 - TAG_W - 6;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_AR     = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [31:2]      addr_q;    // held fetch address (word aligned)
    logic [SETS-1:0]  lru;       // per-set next-victim way
    logic             victim_q;  // way being refilled
    logic [1:0]       beat_q;    // refill beat counter
    logic             err_q;     // any beat returned a non-OKAY response
    logic [31:0]      hold_q;    // requested word captured during refill

    logic [IDX_W-1:0] idx_q;
    logic             unused_addr_bits;

    assign idx_q            = addr_q[IDX_W+5:6];
    assign unused_addr_bits = ^req_addr[1:0];

    // Pick 32-bit word w out of a 128-bit data-array/bus word.
    function automatic logic [31:0] word_sel(input logic [127:0] line,
                                             input logic [1:0]   w);
        return line[{w, 5'b0} +: 32];
    endfunction

    // Static AXI burst shape: 4 beats of 16 bytes.
    assign arlen  = 8'd3;
    assign arsize = 3'b100;

    // Tag and data array addressing: in IDLE the data array index comes
    // straight from the request so the SRAM read overlaps the accept cycle.
    assign tag_index = idx_q;
    assign tag_way   = victim_q;
    assign da_w_way  = victim_q;
    assign da_index  = (state_q == S_IDLE) ? req_addr[IDX_W+5:6] : idx_q;
    assign da_inside = (state_q == S_IDLE)   ? req_addr[5:4] :
                       (state_q == S_REFILL) ? beat_q        : addr_q[5:4];

    // Next-state and per-state output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        rsp_err   = 1'b0;
        tag_wen   = 1'b0;
        arvalid   = 1'b0;
        araddr    = 32'h0;
        rready    = 1'b0;
        da_wen    = 1'b1;
        da_mask   = '1;
        da_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                // Way0 wins when both compare results are asserted.
                if (hit_way0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = word_sel(da_q0, addr_q[3:2]);
                    state_d   = S_IDLE;
                end else if (hit_way1) begin
                    rsp_valid = 1'b1;
                    rsp_data  = word_sel(da_q1, addr_q[3:2]);
                    state_d   = S_IDLE;
                end else begin
                    state_d   = S_AR;
                end
            end

            S_AR: begin
                arvalid = 1'b1;
                araddr  = {addr_q[31:6], 6'b0};
                if (arready) begin
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                rready = 1'b1;
                if (rvalid) begin
                    da_wen   = 1'b0;
                    da_mask  = '0;
                    da_wdata = rdata;
                    // rlast terminates the burst regardless of the beat count.
                    if (rlast) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = hold_q;
                rsp_err   = err_q;
                // A line with a bus error is left tag-invalid.
                tag_wen   = ~err_q;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, held request, refill bookkeeping and replacement bits.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lru      <= '0;
            victim_q <= 1'b0;
            beat_q   <= 2'd0;
            err_q    <= 1'b0;
            hold_q   <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr[31:2];
                    end
                end

                S_LOOKUP: begin
                    // Point the replacement bit at the way that was not used.
                    if (hit_way0) begin
                        lru[idx_q] <= 1'b1;
                    end else if (hit_way1) begin
                        lru[idx_q] <= 1'b0;
                    end else begin
                        victim_q <= lru[idx_q];
                    end
                end

                S_AR: begin
                    if (arready) begin
                        beat_q <= 2'd0;
                        err_q  <= 1'b0;
                    end
                end

                S_REFILL: begin
                    if (rvalid) begin
                        beat_q <= beat_q + 2'd1;
                        if (rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (beat_q == addr_q[5:4]) begin
                            hold_q <= word_sel(rdata, addr_q[3:2]);
                        end
                    end
                end

                S_DONE: begin
                    if (!err_q) begin
                        lru[idx_q] <= ~victim_q;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_icache_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for ysyx_22040632_icache_ctrl: hits on each way, a
// miss with refill, a throttled R channel, a bus error, a double hit with a
// held request, and reset in the middle of a refill.
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_icache_ctrl;

    logic         clk = 1'b0;
    logic         rrst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         hit_way0;
    logic         hit_way1;
    logic         tag_wen;
    logic         tag_way;
    logic [4:0]   tag_index;
    logic         da_wen;
    logic         da_w_way;
    logic [4:0]   da_index;
    logic [1:0]   da_inside;
    logic [127:0] da_mask;
    logic [127:0] da_wdata;
    logic [127:0] da_q0;
    logic [127:0] da_q1;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         rvalid;
    logic         rready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;

    int n_checks = 0;
    int n_fail   = 0;

    // Small tag array model, written only by tag_wen pulses.
    logic [20:0] cur_tag = '0;
    logic [4:0]  cur_idx = '0;
    bit          tvalid [2][32];
    logic [20:0] ttag   [2][32];
    int          tag_wen_cnt = 0;

    ysyx_22040632_icache_ctrl #(.TAG_W(21), .SETS(32)) dut (
        .clk       (clk),
        .rrst_n    (rrst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .hit_way0  (hit_way0),
        .hit_way1  (hit_way1),
        .tag_wen   (tag_wen),
        .tag_way   (tag_way),
        .tag_index (tag_index),
        .da_wen    (da_wen),
        .da_w_way  (da_w_way),
        .da_index  (da_index),
        .da_inside (da_inside),
        .da_mask   (da_mask),
        .da_wdata  (da_wdata),
        .da_q0     (da_q0),
        .da_q1     (da_q1),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rrst_n && tag_wen) begin
            tag_wen_cnt++;
            tvalid[tag_way][tag_index] = 1'b1;
            ttag[tag_way][tag_index]   = cur_tag;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_hit(input int w);
        return tvalid[w][cur_idx] && (ttag[w][cur_idx] == cur_tag);
    endfunction

    // Generic refill data: word w of beat b = 0x1000_00bw.
    function automatic logic [127:0] beat_data(input int b);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) begin
            d[w*32 +: 32] = 32'h1000_0000 | (b << 4) | w;
        end
        return d;
    endfunction

    task automatic issue(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        cur_tag   = a[31:11];
        cur_idx   = a[10:6];
        tick();
        req_valid = 1'b0;
    endtask

    // One accepted R beat; checks the resulting data array write.
    task automatic beat(input logic [127:0] d, input logic [1:0] resp,
                        input logic last, input logic [1:0] exp_inside,
                        input logic exp_way);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        #1;
        check("beat_rready", rready, 1'b1);
        check("beat_wen", da_wen, 1'b0);
        check("beat_mask", da_mask, 128'h0);
        check("beat_inside", da_inside, exp_inside);
        check("beat_way", da_w_way, exp_way);
        check("beat_wdata", da_wdata, d);
        check("beat_rsp_valid", rsp_valid, 1'b0);
        check("beat_tag_wen", tag_wen, 1'b0);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = '0;
    endtask

    // Cycles with rvalid low inside a burst.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check("gap_wen", da_wen, 1'b1);
            check("gap_mask", da_mask, {128{1'b1}});
            check("gap_rsp_valid", rsp_valid, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [127:0] d;

        rrst_n    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        hit_way0  = 1'b0;
        hit_way1  = 1'b0;
        da_q0     = '0;
        da_q1     = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_da_wen", da_wen, 1'b1);
        check("rst_da_mask", da_mask, {128{1'b1}});
        check("rst_arlen", arlen, 8'd3);
        check("rst_arsize", arsize, 3'b100);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_tag_wen", tag_wen, 1'b0);
        check("rst_lru", dut.lru, 32'h0);
        #1 rrst_n = 1'b1;
        tick();

        // ---------------- hit way0: 0x8000_0044 ----------------
        req_valid = 1'b1;
        req_addr  = 32'h8000_0044;
        #1;
        check("h0_accept_ready", req_ready, 1'b1);
        check("h0_accept_index", da_index, 5'd1);
        check("h0_accept_inside", da_inside, 2'd0);
        tick();
        req_valid = 1'b0;
        hit_way0  = 1'b1;
        da_q0     = {32'h0, 32'h0, 32'h0000_0013, 32'h0};
        #1;
        check("h0_rsp_valid", rsp_valid, 1'b1);
        check("h0_rsp_data", rsp_data, 32'h0000_0013);
        check("h0_rsp_err", rsp_err, 1'b0);
        check("h0_req_ready", req_ready, 1'b0);
        check("h0_tag_index", tag_index, 5'd1);
        tick();
        hit_way0 = 1'b0;
        da_q0    = '0;
        #1;
        check("h0_rsp_drop", rsp_valid, 1'b0);
        check("h0_lru1", dut.lru[1], 1'b1);

        // ---------------- hit way1: 0x8000_0048 ----------------
        issue(32'h8000_0048);
        hit_way1 = 1'b1;
        da_q0    = {4{32'h5555_5555}};
        da_q1    = {32'h0, 32'hCAFE_0001, 32'h0, 32'h0};
        #1;
        check("h1_rsp_valid", rsp_valid, 1'b1);
        check("h1_rsp_data", rsp_data, 32'hCAFE_0001);
        tick();
        hit_way1 = 1'b0;
        da_q0    = '0;
        da_q1    = '0;
        #1;
        check("h1_lru1", dut.lru[1], 1'b0);

        // ---------------- miss + refill: 0x8000_1078 ----------------
        issue(32'h8000_1078);
        #1;
        check("m_lookup_rsp", rsp_valid, 1'b0);
        check("m_lookup_arvalid", arvalid, 1'b0);
        tick();
        check("m_ar_valid0", arvalid, 1'b1);
        check("m_ar_addr0", araddr, 32'h8000_1040);
        check("m_ar_rready", rready, 1'b0);
        tick();
        check("m_ar_valid1", arvalid, 1'b1);
        check("m_ar_addr1", araddr, 32'h8000_1040);
        tick();
        arready = 1'b1;
        #1;
        check("m_ar_valid2", arvalid, 1'b1);
        check("m_ar_addr2", araddr, 32'h8000_1040);
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            d = beat_data(b);
            if (b == 3) d[95:64] = 32'hDEAD_BEEF;
            beat(d, 2'b00, b == 3, b[1:0], 1'b0);
        end
        check("m_done_rsp_valid", rsp_valid, 1'b1);
        check("m_done_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("m_done_rsp_err", rsp_err, 1'b0);
        check("m_done_tag_wen", tag_wen, 1'b1);
        check("m_done_tag_way", tag_way, 1'b0);
        check("m_done_rready", rready, 1'b0);
        tick();
        check("m_idle_rsp", rsp_valid, 1'b0);
        check("m_idle_tag_wen", tag_wen, 1'b0);
        check("m_lru1", dut.lru[1], 1'b1);

        // ---------------- throttled R channel: 0x8000_2044 ----------------
        issue(32'h8000_2044);
        tick();
        arready = 1'b1;
        #1;
        check("t_ar_addr", araddr, 32'h8000_2040);
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat(beat_data(b), 2'b00, b == 3, b[1:0], 1'b1);
            if (b < 3) gap(3);
        end
        check("t_done_rsp_valid", rsp_valid, 1'b1);
        check("t_done_rsp_data", rsp_data, 32'h1000_0001);
        check("t_done_tag_wen", tag_wen, 1'b1);
        check("t_done_tag_way", tag_way, 1'b1);
        tick();
        check("t_idle_rsp", rsp_valid, 1'b0);
        check("t_lru1", dut.lru[1], 1'b0);

        // ---------------- bus error: 0x8000_3084 ----------------
        issue(32'h8000_3084);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            beat(beat_data(b), (b == 1) ? 2'b10 : 2'b00, b == 3, b[1:0], 1'b0);
        end
        check("e_done_rsp_valid", rsp_valid, 1'b1);
        check("e_done_rsp_err", rsp_err, 1'b1);
        check("e_done_rsp_data", rsp_data, 32'h1000_0001);
        check("e_done_tag_wen", tag_wen, 1'b0);
        tick();
        check("e_idle_rsp", rsp_valid, 1'b0);
        check("e_lru2", dut.lru[2], 1'b0);
        check("e_tag_wen_cnt", tag_wen_cnt, 2);

        // ---------------- double hit, req_valid held: 0x8000_00C0 ----------------
        req_valid = 1'b1;
        req_addr  = 32'h8000_00C0;
        tick();
        req_addr  = 32'h8000_0100;
        hit_way0  = 1'b1;
        hit_way1  = 1'b1;
        da_q0     = {32'h0, 32'h0, 32'h0, 32'hAAAA_0000};
        da_q1     = {32'h0, 32'h0, 32'h0, 32'hBBBB_0000};
        #1;
        check("b_rsp_valid", rsp_valid, 1'b1);
        check("b_rsp_data", rsp_data, 32'hAAAA_0000);
        check("b_req_ready", req_ready, 1'b0);
        check("b_tag_index", tag_index, 5'd3);
        tick();
        hit_way0 = 1'b0;
        hit_way1 = 1'b0;
        da_q0    = '0;
        da_q1    = '0;
        #1;
        check("b_idle_ready", req_ready, 1'b1);
        check("b_idle_rsp", rsp_valid, 1'b0);
        check("b_idle_da_index", da_index, 5'd4);
        check("b_lru3", dut.lru[3], 1'b1);
        tick();
        req_valid = 1'b0;
        hit_way1  = 1'b1;
        da_q1     = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
        #1;
        check("b2_tag_index", tag_index, 5'd4);
        check("b2_rsp_data", rsp_data, 32'h1234_5678);
        tick();
        hit_way1 = 1'b0;
        da_q1    = '0;

        // ---------------- reset mid-refill: 0x8000_5040 ----------------
        issue(32'h8000_5040);
        hit_way0 = model_hit(0);
        hit_way1 = model_hit(1);
        tick();
        hit_way0 = 1'b0;
        hit_way1 = 1'b0;
        arready  = 1'b1;
        tick();
        arready  = 1'b0;
        for (int b = 0; b < 3; b++) begin
            beat(beat_data(b), 2'b00, 1'b0, b[1:0], 1'b0);
        end
        rvalid = 1'b1;
        rdata  = beat_data(3);
        #2 rrst_n = 1'b0;
        #1;
        check("r_arvalid", arvalid, 1'b0);
        check("r_rready", rready, 1'b0);
        check("r_rsp_valid", rsp_valid, 1'b0);
        check("r_req_ready", req_ready, 1'b1);
        check("r_tag_wen", tag_wen, 1'b0);
        check("r_da_wen", da_wen, 1'b1);
        check("r_lru", dut.lru, 32'h0);
        rvalid = 1'b0;
        rdata  = '0;
        #2 rrst_n = 1'b1;
        tick();
        check("r_tag_wen_cnt", tag_wen_cnt, 2);
        issue(32'h8000_5040);
        hit_way0 = model_hit(0);
        hit_way1 = model_hit(1);
        #1;
        check("r_relookup_rsp", rsp_valid, 1'b0);
        tick();
        hit_way0 = 1'b0;
        hit_way1 = 1'b0;
        check("r_remiss_arvalid", arvalid, 1'b1);
        check("r_remiss_araddr", araddr, 32'h8000_5040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_icache_ctrl.md
Name: ysyx_22040632_icache_ctrl

Overview:
- Sequencing controller for the 2-way, 32-set, 64-byte-line instruction cache data array.
- Accepts fetch requests from the IFU and drives the data array's synchronous read port.
- Uses the external tag array's hit results. On a miss it performs a 4-beat 128-bit AXI read burst and writes each beat into the victim way, then returns the requested 32-bit word.
- Owns the per-set replacement state.

Parameters:
- TAG_W, 21, tag width = addr[31:11]
- SETS, 32, number of sets (index = addr[10:6])

Ports:
- clk  in  1  clock
- rrst_n  in  1  asynchronous active-low reset
- req_valid  in  1  IFU fetch request valid
- req_ready  out  1  controller can accept a request
- req_addr  in  32  fetch address; word aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  instruction word
- rsp_err  out  1  bus error on refill; qualifies rsp_valid
- hit_way0, hit_way1  in  1 each  tag-compare results for the held index/tag
- tag_wen  out  1  one-cycle tag write pulse (valid=1, tag=held tag)
- tag_way  out  1  way written by tag_wen
- tag_index  out  5  held index for the tag array
- da_wen  out  1  data-array write enable, active-low
- da_w_way  out  1  data-array way select; 0 = first way
- da_index  out  5  data-array set index
- da_inside  out  2  128-bit word within line (addr[5:4])
- da_mask  out  128  bit-write enable, active-low; all-zero = full write
- da_wdata  out  128  data-array write data
- da_q0, da_q1  in  128 each  data-array read data for way0 / way1; valid 1 cycle after address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- araddr  out  32  line-aligned address
- arlen  out  8  constant 3
- arsize  out  3  constant 3'b100
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- rdata  in  128  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready=1, da_wen=1, da_mask=all-ones, arlen=3, arsize=4. Replacement bits lru[31:0]=0.
- Address latch: req_addr is captured into addr_q on the handshake (req_valid & req_ready).
- da_index / da_inside source:
  - In IDLE they follow req_addr combinationally so the SRAM read starts in the accept cycle.
  - In all other states they follow addr_q, except during REFILL where da_inside = beat counter.
- tag_index always equals the held index addr_q[10:6].
- IDLE: req_ready=1. On handshake go to LOOKUP.
- LOOKUP (accept cycle +1), req_ready=0:
  - hit_way0: rsp_valid=1, rsp_data = da_q0 word addr_q[3:2]; lru[idx] <= 1; go to IDLE.
  - hit_way1 only: use da_q1; lru[idx] <= 0; go to IDLE.
  - Both hits asserted: treat as way0 hit.
  - Hit latency is exactly 1 cycle after acceptance.
  - No hit: victim <= lru[idx]; go to AR.
- AR:
  - arvalid=1, araddr = {addr_q[31:6], 6'b0}.
  - Hold arvalid and araddr stable until arready.
  - On handshake: beat counter <= 0, err flag <= 0, go to REFILL.
- REFILL: rready=1. On each rvalid beat:
  - da_wen=0, da_w_way=victim, da_mask=0, da_wdata=rdata, da_inside=beat.
  - If beat == addr_q[5:4], capture word addr_q[3:2] into hold register.
  - If rresp != 0, set err flag.
  - beat increments; 2-bit, wraps after 3.
  - On rvalid & rlast go to DONE; rlast ends the burst even if beat != 3.
  - rvalid low: no write, da_wen=1.
- DONE (1 cycle):
  - rsp_valid=1, rsp_data = hold register, rsp_err = err flag.
  - If err flag clear: tag_wen=1, tag_way=victim, lru[idx] <= ~victim.
  - If err flag set: no tag write, lru unchanged.
  - Go to IDLE.
- Refill latency on miss: 1 (LOOKUP) + AR wait + beats + 1.
- Asynchronous reset in any state returns to IDLE immediately:
  - arvalid, rready and rsp_valid drop.
  - lru cleared.
  - Partially written line stays tag-invalid.
- req_valid held during non-IDLE states is ignored; no back-to-back acceptance.

Test Plan:
- Hit way0: accept addr 0x8000_0044 with hit_way0=1 in LOOKUP and da_q0 word1 = 0x0000_0013 -> rsp_valid exactly one cycle after accept, rsp_data=0x13, rsp_err=0, lru[1]=1.
- Miss + refill: addr 0x8000_1078, no hit, lru[1]=0, arready after 2 cycles, 4 beats with rdata beat3 word2 = 0xDEAD_BEEF:
  - araddr=0x8000_1040.
  - Four writes with da_w_way=0, da_inside=0..3, da_mask=0.
  - DONE: rsp_data=0xDEAD_BEEF, tag_wen=1, tag_way=0, lru[1]=1.
- Throttled R channel: rvalid low 3 cycles between beats -> da_wen stays 1 during gaps, beat order preserved, single rsp_valid.
- Bus error: rresp=2'b10 on beat1 -> burst completes, rsp_valid with rsp_err=1, tag_wen never asserted, lru unchanged.
- Both hits asserted plus req_valid held high through LOOKUP -> way0 data returned; next request accepted only when req_ready=1 in IDLE.
- Reset mid-refill after beat 2 -> arvalid, rready and rsp_valid go to 0 the same cycle, req_ready=1, no tag_wen, and a subsequent access to the same line misses.
